// File: rtl/ifetch.sv
// Instruction fetch unit: owns the fetch PC, issues imem requests under a credit limit,
// buffers in-order responses and hands {pc, instr, fault} to decode. Option: IFETCH_BYPASS_EN.
module ifetch #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned     FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            instr_v_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o,
    input  logic            decode_ready_i
);
    localparam int unsigned    AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned    CW      = AW + 1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN  = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t r_state, w_state_nxt;

    logic [XLEN-1:0] r_fetch_pc, r_resp_pc;
    logic [CW-1:0]   r_outstanding, r_kill, r_count;
    logic [AW-1:0]   r_wptr, r_rptr;

    logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_instr [FIFO_DEPTH];
    logic            r_fifo_fault [FIFO_DEPTH];

    logic            w_fire, w_accept, w_wr, w_pop, w_empty, w_byp;
    logic [CW:0]     w_credit;
    logic [CW-1:0]   w_kill_nxt;
    logic [XLEN-1:0] w_resp_instr, w_flush_pc;

    assign w_empty      = (r_count == '0);
    assign w_accept     = imem_rvalid_i & (r_kill == '0) & ~flush_i;
    assign w_resp_instr = imem_err_i ? '0 : imem_rdata_i;
    assign w_flush_pc   = flush_pc_i & ALIGN;
    assign w_credit     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_fire       = imem_req_o & imem_gnt_i;
    // Responses still owed by memory after a flush must all be discarded.
    assign w_kill_nxt   = r_outstanding + CW'(w_fire) - CW'(imem_rvalid_i);

`ifdef IFETCH_BYPASS_EN
    assign w_byp = w_empty & w_accept;
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr  = w_accept & ~(w_byp & decode_ready_i);
    assign w_pop = ~w_empty & ~flush_i & decode_ready_i;

    assign imem_addr_o = r_fetch_pc & ALIGN;
    assign instr_v_o   = (~w_empty | w_byp) & ~flush_i;

    always_comb begin
        pc_o    = r_resp_pc;
        instr_o = '0;
        fault_o = 1'b0;
        if (w_byp) begin
            instr_o = w_resp_instr;
            fault_o = imem_err_i;
        end else if (!w_empty) begin
            pc_o    = r_fifo_pc[r_rptr];
            instr_o = r_fifo_instr[r_rptr];
            fault_o = r_fifo_fault[r_rptr];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req_o  = (r_state == S_RUN) & ~flush_i & (w_credit < DEPTH_C);
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && imem_err_i) w_state_nxt = S_FAULT;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_BOOT;
        endcase
        if (flush_i) w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_outstanding <= '0;
            r_kill        <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rvalid_i);
            if (flush_i) begin
                r_fetch_pc <= w_flush_pc;
                r_resp_pc  <= w_flush_pc;
                r_kill     <= w_kill_nxt;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (imem_rvalid_i && (r_kill != '0)) r_kill <= r_kill - CW'(1);
                if (w_accept) r_resp_pc <= r_resp_pc + XLEN'(4);
                if (w_wr) r_wptr <= r_wptr + AW'(1);
                if (w_pop) r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            end
        end
    end

    // Storage needs no reset: outputs are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo_pc[r_wptr]    <= r_resp_pc;
            r_fifo_instr[r_wptr] <= w_resp_instr;
            r_fifo_fault[r_wptr] <= imem_err_i;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Randomized scoreboard bench for ifetch: memory model, high-level fetch-stream model, decoupled monitor.
module tb_ifetch;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RV   = 32'h8000_0000;
    localparam int unsigned DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i, imem_err_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        flush_i, instr_v_o, fault_o, decode_ready_i;
    logic [31:0] flush_pc_i, instr_o, pc_o;

    always #5 clk = ~clk;

    ifetch #(.XLEN(XLEN), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .instr_v_o(instr_v_o), .instr_o(instr_o), .pc_o(pc_o), .fault_o(fault_o),
        .decode_ready_i(decode_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    int unsigned n_checks = 0, n_pass = 0;
    int unsigned cyc = 0, since_rst = 0, n_grants = 0, n_acc = 0;
    int unsigned n_pops = 0, n_fault_pops = 0;
    logic [31:0] model_pc = RV, err_pc = 32'h1, last_pop_pc = '0;
    bit          faulted = 1'b0, mem_hold = 1'b0;
    int unsigned lat_max = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory: in-order responses, each no earlier than its due cycle.
    always @(negedge clk) begin
        if (rst || mem_hold || mq.size() == 0) begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            imem_err_i    = 1'b0;
        end else if (mq[0].due > cyc) begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            imem_err_i    = 1'b0;
        end else begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_data(mq[0].addr);
            imem_err_i    = (mq[0].addr == err_pc);
        end
    end

    // Reference model: fetch stream as a sequence of PCs since the last redirect.
    initial begin
        mreq_t r;
        int unsigned buffered;
        bit exp_req, exp_v;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mq.delete();
                exp_q.delete();
                model_pc  = RV;
                faulted   = 1'b0;
                since_rst = 0;
                n_acc     = n_pops;
            end else begin
                buffered = n_acc - n_pops;
                exp_req  = (since_rst >= 1) && !faulted && !flush_i && (mq.size() + buffered < DEPTH);
                exp_v    = !flush_i && (buffered > 0 ||
                           (BYP && imem_rvalid_i && mq.size() > 0 && mq[0].live));
                check("req", imem_req_o, exp_req);
                check("instr_v", instr_v_o, exp_v);
                if (imem_req_o) check("req_addr", imem_addr_o, model_pc);
                if (imem_req_o && imem_gnt_i) begin
                    mq.push_back('{addr: model_pc, live: 1'b1, due: cyc + 1 + $urandom_range(0, lat_max)});
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                    n_grants++;
                end
                if (imem_rvalid_i && mq.size() > 0) begin
                    r = mq.pop_front();
                    if (!flush_i && r.live) begin
                        n_acc++;
                        if (r.addr == err_pc) faulted = 1'b1;
                    end
                end
                if (flush_i) begin
                    foreach (mq[i]) mq[i].live = 1'b0;
                    exp_q.delete();
                    n_acc    = n_pops;
                    model_pc = {flush_pc_i[31:2], 2'b00};
                    faulted  = 1'b0;
                end
                since_rst++;
            end
            cyc++;
        end
    end

    // Monitor: compares every handshake against the scoreboard head.
    initial begin
        logic [31:0] pc;
        bit isf;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && instr_v_o && decode_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pc %h expected no instruction", pc_o);
                end else begin
                    pc  = exp_q.pop_front();
                    isf = (pc == err_pc);
                    check("pop_pc", pc_o, pc);
                    check("pop_instr", instr_o, isf ? 32'h0 : mem_data(pc));
                    check("pop_fault", fault_o, isf);
                    last_pop_pc = pc_o;
                    if (fault_o) n_fault_pops++;
                end
                n_pops++;
            end
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush_i = 1'b0;
        #1;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, RV);
        check("rst_v", instr_v_o, 1'b0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, RV);
        check("rst_fault", fault_o, 1'b0);
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_pop(input int unsigned p0, input string name);
        int unsigned t = 0;
        while (n_pops == p0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (n_pops == p0) begin
            n_checks++;
            $display("FAIL %s: no instruction within %0d cycles, required one", name, t);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned g0, p0, f0;
        rst = 1'b1; imem_gnt_i = 1'b0; decode_ready_i = 1'b0;
        flush_i = 1'b0; flush_pc_i = '0;

        // Sequential fetch from the reset vector.
        do_reset();
        imem_gnt_i = 1'b1; decode_ready_i = 1'b1; lat_max = 0;
        cycles(25);

        // Credit limit with a stalled decoder.
        do_reset();
        imem_gnt_i = 1'b1; decode_ready_i = 1'b0;
        g0 = n_grants;
        cycles(12);
        check("credit_fill", n_grants - g0, DEPTH);
        decode_ready_i = 1'b1;
        cycles(1);
        decode_ready_i = 1'b0;
        g0 = n_grants;
        cycles(8);
        check("credit_one", n_grants - g0, 1);

        // Flush with three requests in flight.
        do_reset();
        mem_hold = 1'b1; imem_gnt_i = 1'b0; decode_ready_i = 1'b1;
        cycles(2);
        g0 = n_grants;
        imem_gnt_i = 1'b1;
        cycles(3);
        imem_gnt_i = 1'b0;
        check("inflight3", n_grants - g0, 3);
        flush_i = 1'b1; flush_pc_i = 32'h8000_0102;
        cycles(1);
        flush_i = 1'b0; mem_hold = 1'b0; imem_gnt_i = 1'b1;
        p0 = n_pops;
        wait_pop(p0, "flush_first");
        check("flush_first_pc", last_pop_pc, 32'h8000_0100);

        // Access fault stops fetch until redirected.
        err_pc = 32'h8000_0010;
        do_reset();
        imem_gnt_i = 1'b1; decode_ready_i = 1'b1; lat_max = 2;
        f0 = n_fault_pops;
        cycles(40);
        check("fault_pops", n_fault_pops - f0, 1);
        check("fault_noreq", imem_req_o, 1'b0);
        flush_i = 1'b1; flush_pc_i = 32'h0;
        cycles(1);
        flush_i = 1'b0;
        p0 = n_pops;
        wait_pop(p0, "fault_refetch");
        check("fault_refetch_pc", last_pop_pc, 32'h0);

        // Address wrap.
        lat_max = 0;
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF4;
        cycles(1);
        flush_i = 1'b0;
        cycles(20);
        check("wrap", last_pop_pc < 32'h100, 1'b1);

        // Reset while two entries are buffered.
        do_reset();
        imem_gnt_i = 1'b0; decode_ready_i = 1'b0;
        cycles(1);
        imem_gnt_i = 1'b1;
        cycles(2);
        imem_gnt_i = 1'b0;
        cycles(4);
        check("two_valid", instr_v_o, 1'b1);
        do_reset();
        imem_gnt_i = 1'b1; decode_ready_i = 1'b1;
        cycles(20);

        // Randomized traffic with flushes, faults and occasional resets.
        err_pc = 32'h0000_0040;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            @(negedge clk);
            imem_gnt_i     = ($urandom_range(0, 9) < 7);
            decode_ready_i = ($urandom_range(0, 9) < 6);
            mem_hold       = ($urandom_range(0, 9) == 0);
            lat_max        = $urandom_range(0, 3);
            flush_i        = faulted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
            flush_pc_i     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom_range(0, 127));
        end
        @(negedge clk);
        flush_i = 1'b0;
        cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
